// File: rtl/i2c_eeprom_arbiter.sv
// Round-robin arbiter and byte-command sequencer sharing one I2C master between
// two requesters doing single-byte EEPROM reads/writes, with post-write ack polling.
module i2c_eeprom_arbiter #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter logic [7:0] POLL_MAX = 8'd255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    input  logic       req0_we,
    input  logic       req1_we,
    input  logic [7:0] req0_addr,
    input  logic [7:0] req1_addr,
    input  logic [7:0] req0_wdata,
    input  logic [7:0] req1_wdata,
    output logic [1:0] rsp_done,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy,
    output logic       i2c_cmd_go,
    output logic [2:0] i2c_cmd,
    output logic [7:0] i2c_wdata,
    input  logic       i2c_done,
    input  logic       i2c_ack_n,
    input  logic [7:0] i2c_rdata
);

    localparam logic [2:0] CMD_START = 3'd1;
    localparam logic [2:0] CMD_WRITE = 3'd2;
    localparam logic [2:0] CMD_READ  = 3'd3;
    localparam logic [2:0] CMD_STOP  = 3'd4;
    localparam logic [7:0] DEV_WR    = {DEV_ADDR, 1'b0};
    localparam logic [7:0] DEV_RD    = {DEV_ADDR, 1'b1};

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_DEV, S_ADDR, S_DATA, S_STOP,
        S_POLL_START, S_POLL_DEV, S_POLL_STOP,
        S_RSTART, S_DEVR, S_READ, S_END_STOP, S_DONE, S_HOLD
    } state_t;

    state_t     state_reg;
    logic       rr_last_reg;
    logic       we_reg;
    logic [7:0] addr_reg;
    logic [7:0] wdata_reg;
    logic       err_reg;
    logic       poll_ack_reg;
    logic [7:0] poll_cnt_reg;
    logic [7:0] rdata_reg;

    // With both requests pending the one not served last wins.
    logic grant_sel;
    assign grant_sel = (req_valid == 2'b11) ? ~rr_last_reg : req_valid[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            rr_last_reg  <= 1'b1;
            we_reg       <= 1'b0;
            addr_reg     <= 8'h00;
            wdata_reg    <= 8'h00;
            err_reg      <= 1'b0;
            poll_ack_reg <= 1'b0;
            poll_cnt_reg <= 8'h00;
            rdata_reg    <= 8'h00;
            rsp_done     <= 2'b00;
            rsp_rdata    <= 8'h00;
            rsp_err      <= 1'b0;
            busy         <= 1'b0;
            i2c_cmd_go   <= 1'b0;
            i2c_cmd      <= 3'd0;
            i2c_wdata    <= 8'h00;
        end else begin
            i2c_cmd_go <= 1'b0;
            rsp_done   <= 2'b00;
            case (state_reg)
                S_IDLE: begin
                    if (|req_valid) begin
                        rr_last_reg  <= grant_sel;
                        we_reg       <= grant_sel ? req1_we    : req0_we;
                        addr_reg     <= grant_sel ? req1_addr  : req0_addr;
                        wdata_reg    <= grant_sel ? req1_wdata : req0_wdata;
                        err_reg      <= 1'b0;
                        poll_cnt_reg <= 8'h00;
                        rdata_reg    <= 8'h00;
                        busy         <= 1'b1;
                        i2c_cmd_go   <= 1'b1;
                        i2c_cmd      <= CMD_START;
                        i2c_wdata    <= 8'h00;
                        state_reg    <= S_START;
                    end
                end
                S_START, S_POLL_START, S_RSTART: begin
                    if (i2c_done) begin
                        i2c_cmd_go <= 1'b1;
                        i2c_cmd    <= CMD_WRITE;
                        i2c_wdata  <= (state_reg == S_RSTART) ? DEV_RD : DEV_WR;
                        state_reg  <= (state_reg == S_START)      ? S_DEV :
                                      (state_reg == S_POLL_START) ? S_POLL_DEV : S_DEVR;
                    end
                end
                // A NACK on any addressing/data byte aborts through STOP with an error.
                S_DEV, S_ADDR, S_DATA, S_DEVR: begin
                    if (i2c_done) begin
                        i2c_cmd_go <= 1'b1;
                        i2c_wdata  <= 8'h00;
                        if (i2c_ack_n) begin
                            err_reg   <= 1'b1;
                            i2c_cmd   <= CMD_STOP;
                            state_reg <= S_END_STOP;
                        end else if (state_reg == S_DEV) begin
                            i2c_cmd   <= CMD_WRITE;
                            i2c_wdata <= addr_reg;
                            state_reg <= S_ADDR;
                        end else if (state_reg == S_ADDR && we_reg) begin
                            i2c_cmd   <= CMD_WRITE;
                            i2c_wdata <= wdata_reg;
                            state_reg <= S_DATA;
                        end else if (state_reg == S_ADDR) begin
                            i2c_cmd   <= CMD_START;
                            state_reg <= S_RSTART;
                        end else if (state_reg == S_DATA) begin
                            i2c_cmd   <= CMD_STOP;
                            state_reg <= S_STOP;
                        end else begin
                            i2c_cmd   <= CMD_READ;
                            state_reg <= S_READ;
                        end
                    end
                end
                S_STOP: begin
                    if (i2c_done) begin
                        i2c_cmd_go <= 1'b1;
                        i2c_cmd    <= CMD_START;
                        i2c_wdata  <= 8'h00;
                        state_reg  <= S_POLL_START;
                    end
                end
                S_POLL_DEV: begin
                    if (i2c_done) begin
                        poll_ack_reg <= ~i2c_ack_n;
                        if (i2c_ack_n && poll_cnt_reg != 8'hFF)
                            poll_cnt_reg <= poll_cnt_reg + 8'd1;
                        i2c_cmd_go <= 1'b1;
                        i2c_cmd    <= CMD_STOP;
                        i2c_wdata  <= 8'h00;
                        state_reg  <= S_POLL_STOP;
                    end
                end
                S_POLL_STOP: begin
                    if (i2c_done) begin
                        if (poll_ack_reg || poll_cnt_reg >= POLL_MAX) begin
                            rsp_done  <= rr_last_reg ? 2'b10 : 2'b01;
                            rsp_err   <= ~poll_ack_reg;
                            rsp_rdata <= rdata_reg;
                            state_reg <= S_DONE;
                        end else begin
                            i2c_cmd_go <= 1'b1;
                            i2c_cmd    <= CMD_START;
                            i2c_wdata  <= 8'h00;
                            state_reg  <= S_POLL_START;
                        end
                    end
                end
                S_READ: begin
                    if (i2c_done) begin
                        rdata_reg  <= i2c_rdata;
                        i2c_cmd_go <= 1'b1;
                        i2c_cmd    <= CMD_STOP;
                        i2c_wdata  <= 8'h00;
                        state_reg  <= S_END_STOP;
                    end
                end
                // rdata_reg stays 8'h00 on the error path since it is cleared at grant.
                S_END_STOP: begin
                    if (i2c_done) begin
                        rsp_done  <= rr_last_reg ? 2'b10 : 2'b01;
                        rsp_err   <= err_reg;
                        rsp_rdata <= rdata_reg;
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: state_reg <= S_HOLD;
                S_HOLD: begin
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_eeprom_arbiter.sv
// Directed bench: a behavioural byte-level I2C master logs every command and
// answers with scripted ACK/NACK and read data; checks go through a checking task.
module tb_i2c_eeprom_arbiter;

    localparam logic [2:0] C_START = 3'd1;
    localparam logic [2:0] C_WRITE = 3'd2;
    localparam logic [2:0] C_READ  = 3'd3;
    localparam logic [2:0] C_STOP  = 3'd4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic       req0_we, req1_we;
    logic [7:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
    logic [1:0] rsp_done;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic       i2c_cmd_go;
    logic [2:0] i2c_cmd;
    logic [7:0] i2c_wdata;
    logic       i2c_done  = 1'b0;
    logic       i2c_ack_n = 1'b0;
    logic [7:0] i2c_rdata = 8'h00;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i2c_eeprom_arbiter #(.DEV_ADDR(7'h50), .POLL_MAX(8'd4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid),
        .req0_we(req0_we), .req1_we(req1_we),
        .req0_addr(req0_addr), .req1_addr(req1_addr),
        .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
        .rsp_done(rsp_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .i2c_cmd_go(i2c_cmd_go), .i2c_cmd(i2c_cmd), .i2c_wdata(i2c_wdata),
        .i2c_done(i2c_done), .i2c_ack_n(i2c_ack_n), .i2c_rdata(i2c_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Master model: completes each command four cycles after its go.
    logic [10:0] log_q[$];
    logic [10:0] exp_q[$];
    logic        ack_q[$];
    logic [7:0]  read_byte;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [2:0]  pcmd = 3'd0;
    int          done0_cnt = 0;
    int          done1_cnt = 0;

    always @(posedge clk) begin
        i2c_done <= 1'b0;
        if (rst) begin
            pend <= 1'b0;
        end else if (i2c_cmd_go) begin
            pend <= 1'b1;
            cnt  <= 2;
            pcmd <= i2c_cmd;
            log_q.push_back({i2c_cmd, (i2c_cmd == C_WRITE) ? i2c_wdata : 8'h00});
        end else if (pend) begin
            if (cnt == 0) begin
                pend      <= 1'b0;
                i2c_done  <= 1'b1;
                i2c_ack_n <= 1'b0;
                if (pcmd == C_WRITE && ack_q.size() > 0) i2c_ack_n <= ack_q.pop_front();
                if (pcmd == C_READ) i2c_rdata <= read_byte;
            end else begin
                cnt <= cnt - 1;
            end
        end
        if (rsp_done[0]) done0_cnt <= done0_cnt + 1;
        if (rsp_done[1]) done1_cnt <= done1_cnt + 1;
    end

    function automatic void ex(input logic [2:0] c, input logic [7:0] d);
        exp_q.push_back({c, d});
    endfunction

    function automatic void ex_head(input logic [7:0] addr);
        ex(C_START, 8'h00); ex(C_WRITE, 8'hA0); ex(C_WRITE, addr);
    endfunction

    function automatic void ex_read(input logic [7:0] addr);
        ex_head(addr);
        ex(C_START, 8'h00); ex(C_WRITE, 8'hA1); ex(C_READ, 8'h00); ex(C_STOP, 8'h00);
    endfunction

    function automatic void ex_poll();
        ex(C_START, 8'h00); ex(C_WRITE, 8'hA0); ex(C_STOP, 8'h00);
    endfunction

    task automatic check_stream(input string name);
        string t;
        $display("txn %s: rsp_done=%b rsp_err=%b rsp_rdata=%h cmds=%0d",
                 name, rsp_done, rsp_err, rsp_rdata, log_q.size());
        t = {name, " cmd count"};
        chk(t, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            t = $sformatf("%s cmd[%0d]", name, i);
            chk(t, log_q[i], exp_q[i]);
        end
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_rsp(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (rsp_done != 2'b00) got = 1'b1;
        end
        chk({name, " rsp timeout"}, got, 1'b1);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, " go"}, i2c_cmd_go, 1'b0);
        chk({name, " cmd"}, i2c_cmd, 3'd0);
        chk({name, " wdata"}, i2c_wdata, 8'h00);
        chk({name, " busy"}, busy, 1'b0);
        chk({name, " rsp_done"}, rsp_done, 2'b00);
        chk({name, " rsp_err"}, rsp_err, 1'b0);
        chk({name, " rsp_rdata"}, rsp_rdata, 8'h00);
    endtask

    task automatic check_start(input string name);
        @(negedge clk);
        chk({name, " start go"}, i2c_cmd_go, 1'b1);
        chk({name, " start cmd"}, i2c_cmd, C_START);
        chk({name, " busy"}, busy, 1'b1);
    endtask

    int d0, d1;
    bit reached;

    initial begin
        rst = 1'b1; req_valid = 2'b00;
        req0_we = 1'b0; req1_we = 1'b0;
        req0_addr = 8'h00; req1_addr = 8'h00; req0_wdata = 8'h00; req1_wdata = 8'h00;
        read_byte = 8'h00;
        @(negedge clk); @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle busy", busy, 1'b0);

        // Write on req0 with three NACKed polls before ACK
        req0_we = 1'b1; req0_addr = 8'h10; req0_wdata = 8'hA5;
        ack_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        req_valid = 2'b01;
        check_start("wr0");
        wait_rsp("wr0");
        chk("wr0 rsp_done", rsp_done, 2'b01);
        chk("wr0 rsp_err", rsp_err, 1'b0);
        req_valid = 2'b00;
        ex_head(8'h10); ex(C_WRITE, 8'hA5); ex(C_STOP, 8'h00);
        ex_poll(); ex_poll(); ex_poll(); ex_poll();
        check_stream("wr0");
        @(negedge clk);
        chk("wr0 pulse width", rsp_done, 2'b00);
        chk("wr0 hold busy", busy, 1'b1);
        @(negedge clk);

        // Read on req1
        req1_we = 1'b0; req1_addr = 8'h10; read_byte = 8'hA5;
        ack_q = '{1'b0, 1'b0, 1'b0};
        req_valid = 2'b10;
        check_start("rd1");
        wait_rsp("rd1");
        chk("rd1 rsp_done", rsp_done, 2'b10);
        chk("rd1 rsp_rdata", rsp_rdata, 8'hA5);
        chk("rd1 rsp_err", rsp_err, 1'b0);
        req_valid = 2'b00;
        ex_read(8'h10);
        check_stream("rd1");
        @(negedge clk);
        chk("rd1 rdata held", rsp_rdata, 8'hA5);
        @(negedge clk);

        // Both requests right after reset: req0 first, then re-assert both -> req1
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rr reset busy", busy, 1'b0);
        req0_we = 1'b0; req0_addr = 8'h20; req1_we = 1'b0; req1_addr = 8'h30;
        read_byte = 8'h11;
        ack_q.delete();
        req_valid = 2'b11;
        check_start("rr a");
        wait_rsp("rr a");
        chk("rr a rsp_done", rsp_done, 2'b01);
        chk("rr a rsp_rdata", rsp_rdata, 8'h11);
        req_valid = 2'b10;
        ex_read(8'h20);
        check_stream("rr a");
        @(negedge clk);
        req_valid = 2'b11;
        chk("rr hold go", i2c_cmd_go, 1'b0);
        @(negedge clk);
        chk("rr idle go", i2c_cmd_go, 1'b0);
        chk("rr idle busy", busy, 1'b0);
        @(negedge clk);
        chk("rr b go", i2c_cmd_go, 1'b1);
        wait_rsp("rr b");
        chk("rr b rsp_done", rsp_done, 2'b10);
        req_valid = 2'b01;
        ex_read(8'h30);
        check_stream("rr b");
        @(negedge clk); @(negedge clk);
        check_start("rr c");
        wait_rsp("rr c");
        chk("rr c rsp_done", rsp_done, 2'b01);
        req_valid = 2'b00;
        ex_read(8'h20);
        check_stream("rr c");
        @(negedge clk); @(negedge clk);

        // Device address NACK on a read
        req0_we = 1'b0; req0_addr = 8'h55;
        ack_q = '{1'b1};
        req_valid = 2'b01;
        check_start("nack");
        wait_rsp("nack");
        chk("nack rsp_done", rsp_done, 2'b01);
        chk("nack rsp_err", rsp_err, 1'b1);
        chk("nack rsp_rdata", rsp_rdata, 8'h00);
        req_valid = 2'b00;
        ex(C_START, 8'h00); ex(C_WRITE, 8'hA0); ex(C_STOP, 8'h00);
        check_stream("nack");
        @(negedge clk); @(negedge clk);

        // Poll timeout: every poll NACKed, POLL_MAX = 4
        req1_we = 1'b1; req1_addr = 8'h44; req1_wdata = 8'h5A;
        ack_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        req_valid = 2'b10;
        check_start("ptmo");
        wait_rsp("ptmo");
        chk("ptmo rsp_done", rsp_done, 2'b10);
        chk("ptmo rsp_err", rsp_err, 1'b1);
        req_valid = 2'b00;
        ex_head(8'h44); ex(C_WRITE, 8'h5A); ex(C_STOP, 8'h00);
        ex_poll(); ex_poll(); ex_poll(); ex_poll();
        check_stream("ptmo");
        @(negedge clk); @(negedge clk);

        // Reset while waiting for the WR(addr) done
        req0_we = 1'b1; req0_addr = 8'h77; req0_wdata = 8'h01;
        ack_q = '{1'b0, 1'b0, 1'b0, 1'b0};
        req_valid = 2'b01;
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            @(negedge clk);
            if (log_q.size() == 3) reached = 1'b1;
        end
        chk("abort reach addr", reached, 1'b1);
        rst = 1'b1;
        d0 = done0_cnt; d1 = done1_cnt;
        @(negedge clk);
        check_idle_outputs("abort");
        rst = 1'b0;
        req_valid = 2'b00;
        repeat (20) @(negedge clk);
        $display("txn abort: cmds=%0d rsp_done_count=%0d", log_q.size(), done0_cnt + done1_cnt);
        chk("abort no stop", log_q.size(), 3);
        chk("abort no rsp0", done0_cnt, d0);
        chk("abort no rsp1", done1_cnt, d1);
        log_q.delete();
        ack_q = '{1'b0, 1'b0, 1'b0, 1'b0};
        req_valid = 2'b01;
        check_start("reissue");
        wait_rsp("reissue");
        chk("reissue rsp_done", rsp_done, 2'b01);
        chk("reissue rsp_err", rsp_err, 1'b0);
        req_valid = 2'b00;
        ex_head(8'h77); ex(C_WRITE, 8'h01); ex(C_STOP, 8'h00);
        ex_poll();
        check_stream("reissue");
        @(negedge clk); @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
